// File: rtl/halt_pkg.sv
// Shared encodings for the halt monitor: halt causes and RUN/HALTED state.
package halt_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_NOP      = 2'b01,
    CAUSE_MISALIGN = 2'b10,
    CAUSE_LIMIT    = 2'b11
  } cause_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: reset is synchronous here, so it lives inside the clocked block
  // and is absent from the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/halt_monitor.sv
// Watches a retiring core and halts on a NOP run, a misaligned fetch or a cycle limit.
// Define HALT_CYCLE_LIMIT_EN to build in the cycle-limit trigger (cause 11).
module halt_monitor
  import halt_pkg::*;
#(
  parameter int NOP_LIMIT   = 6,
  parameter int CYCLE_LIMIT = 10000000,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ret_valid,
  input  logic [31:0]      ret_pc,
  input  logic [31:0]      ret_ir,
  input  logic [31:0]      fetch_pc,
  output logic             halt,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [31:0]      last_pc
);

  state_t           state;
  cause_t           cause_q;
  cause_t           next_cause;
  logic [CNT_W-1:0] nop_cnt;
  logic             running;
  logic             is_nop;
  logic             is_real;
  logic             nop_hit;
  logic             misalign;
  logic             limit_hit;
  logic             unused_fetch_hi;

  assign running         = (state == RUN);
  assign is_nop          = ret_valid && (ret_ir == '0);
  assign is_real         = ret_valid && (ret_ir != '0);
  assign misalign        = (fetch_pc[1:0] != 2'b00);
  assign unused_fetch_hi = ^fetch_pc[31:2];

  // The retiring NOP that would make the run NOP_LIMIT long fires the trigger.
  assign nop_hit = is_nop && (nop_cnt == CNT_W'(NOP_LIMIT - 1));

`ifdef HALT_CYCLE_LIMIT_EN
  assign limit_hit = (64'(cycle_cnt) > 64'(CYCLE_LIMIT));
`else
  assign limit_hit = 1'b0;
`endif

  // NOTE: next_cause gets a default first so no path through the block
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    next_cause = CAUSE_NONE;
    if (misalign) begin
      next_cause = CAUSE_MISALIGN;
    end else if (nop_hit) begin
      next_cause = CAUSE_NOP;
    end else if (limit_hit) begin
      next_cause = CAUSE_LIMIT;
    end
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= RUN;
      halt    <= 1'b0;
      cause_q <= CAUSE_NONE;
      last_pc <= '0;
    end else if (running) begin
      if (is_real) begin
        last_pc <= ret_pc;
      end
      if (next_cause != CAUSE_NONE) begin
        state   <= HALTED;
        halt    <= 1'b1;
        cause_q <= next_cause;
      end
    end
  end

  assign halt_cause = cause_q;

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (running),
    .count (cycle_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (running && ret_valid),
    .count (retired_cnt)
  );

  // Gaps (ret_valid=0) neither clear nor advance the run.
  sat_counter #(.WIDTH(CNT_W)) u_nop_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (running && is_real),
    .inc   (running && is_nop),
    .count (nop_cnt)
  );

endmodule

// File: tb/tb_halt_monitor.sv
// Bench for halt_monitor: three parameterisations share one stimulus stream and
// are compared against a behavioural model plus directed constant checks.
module tb_halt_monitor;

  localparam int NOP_LIMIT = 6;
  localparam logic [31:0] ALIGNED = 32'h0000_1000;
`ifdef HALT_CYCLE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        halt;
    logic [1:0]  cause;
    logic [63:0] cyc;
    logic [63:0] ret;
    logic [31:0] last_pc;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ret_valid = 1'b0;
  logic [31:0] ret_pc = '0;
  logic [31:0] ret_ir = '0;
  logic [31:0] fetch_pc = '0;

  always #5 clk = ~clk;

  // dut 0: defaults, dut 1: CYCLE_LIMIT=20, dut 2: CNT_W=4
  logic        h0, h1, h2;
  logic [1:0]  c0, c1, c2;
  logic [31:0] cy0, cy1, rt0, rt1, lp0, lp1, lp2;
  logic [3:0]  cy2, rt2;

  halt_monitor u_dflt (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_ir(ret_ir),
    .fetch_pc(fetch_pc), .halt(h0), .halt_cause(c0), .cycle_cnt(cy0),
    .retired_cnt(rt0), .last_pc(lp0)
  );

  halt_monitor #(.CYCLE_LIMIT(20)) u_lim (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_ir(ret_ir),
    .fetch_pc(fetch_pc), .halt(h1), .halt_cause(c1), .cycle_cnt(cy1),
    .retired_cnt(rt1), .last_pc(lp1)
  );

  halt_monitor #(.CNT_W(4)) u_narrow (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_ir(ret_ir),
    .fetch_pc(fetch_pc), .halt(h2), .halt_cause(c2), .cycle_cnt(cy2),
    .retired_cnt(rt2), .last_pc(lp2)
  );

  snap_t obs [3];
  assign obs[0] = {h0, c0, 64'(cy0), 64'(rt0), lp0};
  assign obs[1] = {h1, c1, 64'(cy1), 64'(rt1), lp1};
  assign obs[2] = {h2, c2, 64'(cy2), 64'(rt2), lp2};

  // Behavioural model: one record per instance, plain integer arithmetic.
  longint      m_cyc [3];
  longint      m_ret [3];
  longint      m_nop [3];
  longint      m_max [3];
  longint      m_limit [3];
  bit          m_halted [3];
  int          m_cause [3];
  logic [31:0] m_last [3];

  int total = 0;
  int bad   = 0;

  function automatic longint sat(input longint v, input longint top);
    return (v > top) ? top : v;
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [31:0] pc,
                            input logic [31:0] ir, input logic [31:0] fpc);
    for (int k = 0; k < 3; k++) begin
      if (!r) begin
        m_cyc[k] = 0; m_ret[k] = 0; m_nop[k] = 0;
        m_halted[k] = 0; m_cause[k] = 0; m_last[k] = '0;
      end else if (!m_halted[k]) begin
        int cause;
        cause = 0;
        if ((fpc % 4) != 0) cause = 2;
        else if (v && ir == 0 && m_nop[k] + 1 == NOP_LIMIT) cause = 1;
        else if (LIMIT_EN && m_cyc[k] > m_limit[k]) cause = 3;
        if (cause != 0) begin
          m_halted[k] = 1;
          m_cause[k]  = cause;
        end
        m_cyc[k] = sat(m_cyc[k] + 1, m_max[k]);
        if (v) begin
          m_ret[k] = sat(m_ret[k] + 1, m_max[k]);
          if (ir == 0) m_nop[k] = m_nop[k] + 1;
          else begin
            m_nop[k]  = 0;
            m_last[k] = pc;
          end
        end
      end
    end
  endtask

  function automatic snap_t expect_of(input int k);
    snap_t s;
    s.halt    = m_halted[k];
    s.cause   = 2'(m_cause[k]);
    s.cyc     = 64'(m_cyc[k]);
    s.ret     = 64'(m_ret[k]);
    s.last_pc = m_last[k];
    return s;
  endfunction

  task automatic tick(input logic r, input logic v, input logic [31:0] pc,
                      input logic [31:0] ir, input logic [31:0] fpc);
    rst = r; ret_valid = v; ret_pc = pc; ret_ir = ir; fetch_pc = fpc;
    @(posedge clk);
    model_step(r, v, pc, ir, fpc);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, '0, '0, ALIGNED);
  endtask

  task automatic nop();
    tick(1'b1, 1'b1, $urandom() & 32'hFFFF_FFFC, '0, ALIGNED);
  endtask

  function automatic logic [31:0] nz_ir();
    return $urandom() | 32'h0000_0013;
  endfunction

  task automatic test_reset();
    tick(1'b0, 1'b1, 32'h0000_0044, 32'h0, 32'h0000_0003);
    tick(1'b0, 1'b1, 32'h0000_0048, nz_ir(), 32'h0000_0001);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== snap_t'(0)) begin
        bad++;
        $display("FAIL reset_state dut%0d got=%h want=0", k, obs[k]);
      end
    end
  endtask

  task automatic test_nop_run();
    do_reset();
    repeat (5) nop();
    tick(1'b1, 1'b1, 32'h0000_0040, nz_ir(), ALIGNED);
    repeat (5) nop();
    total++;
    if (h0 !== 1'b0) begin
      bad++;
      $display("FAIL nop_run_early dut0 halt got=%b want=0", h0);
    end
    nop();
    total++;
    if ({h0, c0} !== 3'b101) begin
      bad++;
      $display("FAIL nop_run_halt dut0 halt/cause got=%b/%b want=1/01", h0, c0);
    end
    total++;
    if (rt0 !== 32'd12 || lp0 !== 32'h40) begin
      bad++;
      $display("FAIL nop_run_counts dut0 retired/last_pc got=%0d/%h want=12/40", rt0, lp0);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== expect_of(k)) begin
        bad++;
        $display("FAIL nop_run_model dut%0d got=%h want=%h", k, obs[k], expect_of(k));
      end
    end
  endtask

  task automatic test_misalign_tie();
    do_reset();
    repeat (5) nop();
    tick(1'b1, 1'b1, 32'h0000_0100, '0, 32'h0000_0102);
    total++;
    if ({h0, c0} !== 3'b110) begin
      bad++;
      $display("FAIL misalign_tie dut0 halt/cause got=%b/%b want=1/10", h0, c0);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== expect_of(k)) begin
        bad++;
        $display("FAIL misalign_model dut%0d got=%h want=%h", k, obs[k], expect_of(k));
      end
    end
  endtask

  task automatic test_gaps();
    do_reset();
    for (int i = 1; i <= NOP_LIMIT; i++) begin
      repeat ($urandom_range(1, 2)) tick(1'b1, 1'b0, $urandom(), nz_ir(), ALIGNED);
      total++;
      if (h0 !== 1'b0) begin
        bad++;
        $display("FAIL gaps_early dut0 before nop %0d halt got=%b want=0", i, h0);
      end
      nop();
    end
    total++;
    if ({h0, c0} !== 3'b101 || rt0 !== 32'd6) begin
      bad++;
      $display("FAIL gaps_halt dut0 halt/cause/retired got=%b/%b/%0d want=1/01/6", h0, c0, rt0);
    end
  endtask

  task automatic test_cycle_limit();
    do_reset();
    repeat (21) tick(1'b1, 1'b0, '0, '0, ALIGNED);
    total++;
    if (h1 !== 1'b0 || cy1 !== 32'd21) begin
      bad++;
      $display("FAIL limit_early dut1 halt/cycle got=%b/%0d want=0/21", h1, cy1);
    end
    tick(1'b1, 1'b0, '0, '0, ALIGNED);
    total++;
    if (h1 !== LIMIT_EN || c1 !== (LIMIT_EN ? 2'b11 : 2'b00)) begin
      bad++;
      $display("FAIL limit_halt dut1 halt/cause got=%b/%b want=%b/%b",
               h1, c1, LIMIT_EN, LIMIT_EN ? 2'b11 : 2'b00);
    end
    repeat (8) tick(1'b1, 1'b0, '0, '0, ALIGNED);
    total++;
    if (cy1 !== (LIMIT_EN ? 32'd22 : 32'd30)) begin
      bad++;
      $display("FAIL limit_freeze dut1 cycle got=%0d want=%0d", cy1, LIMIT_EN ? 22 : 30);
    end
    total++;
    if (cy2 !== 4'd15 || h0 !== 1'b0 || cy0 !== 32'd30) begin
      bad++;
      $display("FAIL limit_others dut2 cycle=%0d (want 15) dut0 halt/cycle=%b/%0d (want 0/30)",
               cy2, h0, cy0);
    end
  endtask

  task automatic test_halt_reset();
    do_reset();
    tick(1'b1, 1'b1, 32'h0000_0080, nz_ir(), 32'h0000_0002);
    repeat (5) tick(1'b1, 1'b1, $urandom() & 32'hFFFF_FFFC, nz_ir(), $urandom());
    total++;
    if (obs[0] !== {1'b1, 2'b10, 64'd1, 64'd1, 32'h80}) begin
      bad++;
      $display("FAIL halted_frozen dut0 got=%h", obs[0]);
    end
    tick(1'b0, 1'b1, 32'h0000_0090, nz_ir(), 32'h0000_0001);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs[k] !== snap_t'(0)) begin
        bad++;
        $display("FAIL halted_reset dut%0d got=%h want=0", k, obs[k]);
      end
    end
    tick(1'b1, 1'b0, '0, '0, ALIGNED);
    total++;
    if (h0 !== 1'b0 || cy0 !== 32'd1) begin
      bad++;
      $display("FAIL resume_count dut0 halt/cycle got=%b/%0d want=0/1", h0, cy0);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (20) tick(1'b1, 1'b1, $urandom() & 32'hFFFF_FFFC, nz_ir(), ALIGNED);
    total++;
    if (rt2 !== 4'd15 || cy2 !== 4'd15 || h2 !== 1'b0) begin
      bad++;
      $display("FAIL saturate dut2 retired/cycle/halt got=%0d/%0d/%b want=15/15/0", rt2, cy2, h2);
    end
    total++;
    if (rt0 !== 32'd20) begin
      bad++;
      $display("FAIL saturate_wide dut0 retired got=%0d want=20", rt0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic        r, v;
      logic [31:0] ir, fpc;
      r   = ($urandom_range(0, 39) != 0);
      v   = ($urandom_range(0, 3) != 0);
      ir  = ($urandom_range(0, 9) < 7) ? 32'h0 : nz_ir();
      fpc = ($urandom_range(0, 59) == 0) ? ($urandom() | 32'h1) : ($urandom() & 32'hFFFF_FFFC);
      tick(r, v, $urandom(), ir, fpc);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs[k] !== expect_of(k)) begin
          bad++;
          $display("FAIL random_model cycle %0d dut%0d got=%h want=%h", n, k, obs[k], expect_of(k));
        end
      end
    end
  endtask

  initial begin
    m_max[0]   = (longint'(1) << 32) - 1;
    m_max[1]   = (longint'(1) << 32) - 1;
    m_max[2]   = 15;
    m_limit[0] = 10000000;
    m_limit[1] = 20;
    m_limit[2] = 10000000;
    test_reset();
    test_nop_run();
    test_misalign_tie();
    test_gaps();
    test_cycle_limit();
    test_halt_reset();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
